// File: rtl/ls_pkg.sv
// ls_pkg: shared FSM type, default geometry and index-width helper for the weight fetch controller
package ls_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} wfetch_state_t;
    localparam int WF_ROWS   = 4;
    localparam int WF_DATA_W = 64;
    localparam int WF_ADDR_W = 16;
    function automatic int row_idx_w(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction
endpackage

// File: rtl/wfetch_lat_pipe.sv
// wfetch_lat_pipe: LAT-stage {valid,row} shift register that tracks reads in flight to the weight memory
//   i_clk, i_reset_n : clock, async active-low reset (clears all in-flight entries)
//   i_push, i_row    : a read was issued this cycle for row i_row
//   o_cap_valid      : mem_rdata this cycle belongs to row o_cap_row
//   o_empty          : no read is in flight
module wfetch_lat_pipe #(
    parameter int LAT = 2,
    parameter int RW  = 2
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_push,
    input  logic [RW-1:0] i_row,
    output logic          o_cap_valid,
    output logic [RW-1:0] o_cap_row,
    output logic          o_empty
);
    logic [LAT-1:0]         r_v;
    logic [LAT-1:0][RW-1:0] r_row;
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_v   <= '0;
            r_row <= '0;
        end else begin
            r_v[0]   <= i_push;
            r_row[0] <= i_row;
            for (int i = 1; i < LAT; i++) begin
                r_v[i]   <= r_v[i-1];
                r_row[i] <= r_row[i-1];
            end
        end
    end
    assign o_cap_valid = r_v[LAT-1];
    assign o_cap_row   = r_row[LAT-1];
    assign o_empty     = ~|r_v;
endmodule

// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl: handshaked fetch of one weight word per MXU row into held row registers
//   i_clk, i_reset_n         : clock, async active-low reset
//   i_start, i_base_addr,
//   i_num_rows               : fetch request, accepted only in IDLE
//   o_mem_en, o_mem_addr,
//   i_mem_rdata              : weight memory read port, data MEM_LAT cycles after a granted read
//   i_mem_gnt                : memory grant, present only when WFETCH_MEM_GNT_EN is defined
//   o_weight_to_mxu          : row r at bits [r*DATA_W +: DATA_W]
//   o_weights_valid, o_done  : set complete (level) / first cycle of it (pulse)
//   i_weight_ack             : consumer releases the set in HOLD
//   o_busy                   : any state other than IDLE
module weight_fetch_ctrl
    import ls_pkg::*;
#(
    parameter int ROWS    = WF_ROWS,
    parameter int DATA_W  = WF_DATA_W,
    parameter int ADDR_W  = WF_ADDR_W,
    parameter int MEM_LAT = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_start,
    input  logic [ADDR_W-1:0]      i_base_addr,
    input  logic [$clog2(ROWS):0]  i_num_rows,
    output logic                   o_mem_en,
    output logic [ADDR_W-1:0]      o_mem_addr,
`ifdef WFETCH_MEM_GNT_EN
    input  logic                   i_mem_gnt,
`endif
    input  logic [DATA_W-1:0]      i_mem_rdata,
    output logic [DATA_W*ROWS-1:0] o_weight_to_mxu,
    output logic                   o_weights_valid,
    input  logic                   i_weight_ack,
    output logic                   o_busy,
    output logic                   o_done
);
    localparam int CW = $clog2(ROWS) + 1;
    localparam int RW = row_idx_w(ROWS);
    wfetch_state_t               r_state, w_next;
    logic [ADDR_W-1:0]           r_base;
    logic [CW-1:0]               r_n, r_rc, w_n_eff;
    logic [ROWS-1:0][DATA_W-1:0] r_w;
    logic                        r_done, w_gnt, w_push, w_last, w_cap_valid, w_empty;
    logic [RW-1:0]               w_cap_row;
`ifdef WFETCH_MEM_GNT_EN
    assign w_gnt = i_mem_gnt;
`else
    assign w_gnt = 1'b1;
`endif
    // zero or oversize requests fetch the whole array
    assign w_n_eff = (i_num_rows == '0 || i_num_rows > CW'(ROWS)) ? CW'(ROWS) : i_num_rows;
    assign w_push  = (r_state == ISSUE) & w_gnt;
    assign w_last  = r_rc == r_n - 1'b1;
    wfetch_lat_pipe #(.LAT(MEM_LAT), .RW(RW)) u_pipe (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_push      (w_push),
        .i_row       (RW'(r_rc)),
        .o_cap_valid (w_cap_valid),
        .o_cap_row   (w_cap_row),
        .o_empty     (w_empty)
    );
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_start ? ISSUE : IDLE;
            ISSUE:   w_next = (w_push && w_last) ? DRAIN : ISSUE;
            DRAIN:   w_next = w_empty ? HOLD : DRAIN;
            HOLD:    w_next = i_weight_ack ? IDLE : HOLD;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        o_mem_en        = r_state == ISSUE;
        o_mem_addr      = (r_state == ISSUE) ? r_base + ADDR_W'(r_rc) : '0;
        o_weights_valid = r_state == HOLD;
        o_busy          = r_state != IDLE;
        o_done          = r_done;
        o_weight_to_mxu = r_w;
    end
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_base <= '0;
            r_n    <= '0;
            r_rc   <= '0;
            r_w    <= '0;
            r_done <= 1'b0;
        end else begin
            // done marks the DRAIN->HOLD transition, i.e. the first HOLD cycle
            r_done <= (r_state == DRAIN) && w_empty;
            if (r_state == IDLE && i_start) begin
                r_base <= i_base_addr;
                r_n    <= w_n_eff;
                r_rc   <= '0;
                for (int r = 0; r < ROWS; r++)
                    if (CW'(r) >= w_n_eff) r_w[r] <= '0;
            end
            if (w_push) r_rc <= r_rc + 1'b1;
            if (w_cap_valid) r_w[w_cap_row] <= i_mem_rdata;
        end
    end
endmodule

// File: tb/tb_weight_fetch_ctrl.sv
module tb_weight_fetch_ctrl;
    localparam int ROWS = 4, DW = 64, AW = 16, LAT = 2;
    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, mem_gnt = 1'b1, weight_ack = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [2:0] num_rows = '0;
    logic mem_en, weights_valid, busy, done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic [DW*ROWS-1:0] weight_to_mxu;
    int n_cmp = 0, n_bad = 0;
    logic [63:0] mem_ovr [logic [15:0]];
    logic [31:0] salt = 32'h1234_5678;
    bit gnt_pat [$];
    logic [15:0] obs_addr [$];
    bit obs_gnt [$];
    int obs_en, obs_first, obs_last, obs_vedge;
    logic obs_done;
    logic [63:0] rd_pipe [LAT];

    always #5 clk = ~clk;

    weight_fetch_ctrl #(.ROWS(ROWS), .DATA_W(DW), .ADDR_W(AW), .MEM_LAT(LAT)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_base_addr(base_addr),
        .i_num_rows(num_rows), .o_mem_en(mem_en), .o_mem_addr(mem_addr),
`ifdef WFETCH_MEM_GNT_EN
        .i_mem_gnt(mem_gnt),
`endif
        .i_mem_rdata(mem_rdata), .o_weight_to_mxu(weight_to_mxu),
        .o_weights_valid(weights_valid), .i_weight_ack(weight_ack),
        .o_busy(busy), .o_done(done)
    );

    function automatic logic [63:0] mem_word(input logic [15:0] a);
        return mem_ovr.exists(a) ? mem_ovr[a] : {salt, a ^ 16'h5A5A, a};
    endfunction

    // memory with fixed read latency; junk on the bus whenever no read is due
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= (mem_en && mem_gnt) ? mem_word(mem_addr) : {$urandom, $urandom};
    end
    assign mem_rdata = rd_pipe[LAT-1];

    function automatic int n_eff(input logic [2:0] nr);
        return (nr == 0 || nr > 3'(ROWS)) ? ROWS : int'(nr);
    endfunction

    function automatic logic [DW*ROWS-1:0] exp_vec(input logic [15:0] b, input logic [2:0] nr);
        logic [DW*ROWS-1:0] v = '0;
        for (int r = 0; r < n_eff(nr); r++) v[r*DW +: DW] = mem_word(16'(b + r));
        return v;
    endfunction

    function automatic bit gnt_at(input int c);
        return (c >= 1 && c <= gnt_pat.size()) ? gnt_pat[c-1] : 1'b1;
    endfunction

    // cycle at which the n-th grant happens (cycle 1 follows the accept edge)
    function automatic int exp_g(input int n);
        int cnt = 0;
        for (int c = 1; c < 200; c++) begin
            if (gnt_at(c)) cnt++;
            if (cnt == n) return c;
        end
        return -1;
    endfunction

    task automatic do_fetch(input logic [15:0] b, input logic [2:0] nr, input int spur);
        obs_addr.delete();
        obs_gnt.delete();
        obs_en = 0; obs_first = -1; obs_last = -1; obs_vedge = -1; obs_done = 1'b0;
        base_addr = b; num_rows = nr; start = 1'b1;
        @(negedge clk);
        start = 1'b0; base_addr = 16'($urandom); num_rows = 3'($urandom);
        for (int c = 1; c <= 100; c++) begin
            if (weights_valid) begin
                obs_vedge = c - 1;
                obs_done = done;
                break;
            end
            if (mem_en) begin
                obs_en++;
                if (obs_first < 0) obs_first = c;
                obs_last = c;
                obs_addr.push_back(mem_addr);
                obs_gnt.push_back(gnt_at(c));
            end
            mem_gnt = gnt_at(c);
            start = (c == spur);
            @(negedge clk);
        end
        start = 1'b0;
        mem_gnt = 1'b1;
    endtask

    task automatic release_set();
        weight_ack = 1'b1;
        @(negedge clk);
        weight_ack = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({mem_en, mem_addr, weights_valid, busy, done} !== '0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b/%h/%b/%b/%b want all 0", mem_en, mem_addr, weights_valid, busy, done);
        end
        n_cmp++;
        if (weight_to_mxu !== '0) begin n_bad++; $display("FAIL reset_weights: got %h want 0", weight_to_mxu); end
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        mem_ovr.delete();
        for (int i = 0; i < 4; i++) mem_ovr[16'(16'h0100 + i)] = 64'(8'hA0 + i);
        do_fetch(16'h0100, 3'd4, 0);
        n_cmp++;
        if (obs_en !== 4 || obs_first !== 1 || obs_last !== 4) begin
            n_bad++; $display("FAIL basic_en: got cnt %0d cycles %0d..%0d want 4 cycles 1..4", obs_en, obs_first, obs_last);
        end
        for (int i = 0; i < obs_addr.size(); i++) begin
            n_cmp++;
            if (obs_addr[i] !== 16'(16'h0100 + i)) begin n_bad++; $display("FAIL basic_addr%0d: got %h want %h", i, obs_addr[i], 16'(16'h0100 + i)); end
        end
        n_cmp++;
        if (obs_vedge !== 7 || obs_done !== 1'b1) begin
            n_bad++; $display("FAIL basic_valid: got edge %0d done %b want edge 7 done 1", obs_vedge, obs_done);
        end
        n_cmp++;
        if (weight_to_mxu !== {64'hA3, 64'hA2, 64'hA1, 64'hA0}) begin n_bad++; $display("FAIL basic_weights: got %h want A3..A0", weight_to_mxu); end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || weights_valid !== 1'b1) begin n_bad++; $display("FAIL basic_done_pulse: got done %b valid %b want 0 1", done, weights_valid); end
        release_set();
        n_cmp++;
        if (weights_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_release: got valid %b busy %b want 0 0", weights_valid, busy); end
    endtask

    task automatic test_partial();
        logic [DW*ROWS-1:0] ev;
        mem_ovr.delete();
        for (int i = 0; i < 4; i++) mem_ovr[16'(16'h0200 + i)] = '1;
        do_fetch(16'h0200, 3'd4, 0);
        n_cmp++;
        if (weight_to_mxu !== '1) begin n_bad++; $display("FAIL partial_prior: got %h want all ones", weight_to_mxu); end
        release_set();
        do_fetch(16'h0300, 3'd2, 0);
        ev = exp_vec(16'h0300, 3'd2);
        n_cmp++;
        if (obs_en !== 2) begin n_bad++; $display("FAIL partial_en: got %0d want 2", obs_en); end
        n_cmp++;
        if (weight_to_mxu !== ev) begin n_bad++; $display("FAIL partial_weights: got %h want %h", weight_to_mxu, ev); end
        release_set();
        for (int k = 0; k < 2; k++) begin
            do_fetch(16'h0500, k == 0 ? 3'd0 : 3'd7, 0);
            n_cmp++;
            if (obs_en !== 4 || weight_to_mxu !== exp_vec(16'h0500, 3'd4)) begin
                n_bad++; $display("FAIL clamp_%0d: got %0d reads %h want 4 reads %h", k, obs_en, weight_to_mxu, exp_vec(16'h0500, 3'd4));
            end
            release_set();
        end
    endtask

    task automatic test_wrap();
        logic [15:0] ea [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        do_fetch(16'hFFFE, 3'd4, 0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (obs_addr.size() <= i || obs_addr[i] !== ea[i]) begin n_bad++; $display("FAIL wrap_addr%0d: got %h want %h", i, obs_addr.size() > i ? obs_addr[i] : 16'hxxxx, ea[i]); end
        end
        n_cmp++;
        if (weight_to_mxu !== exp_vec(16'hFFFE, 3'd4)) begin n_bad++; $display("FAIL wrap_weights: got %h want %h", weight_to_mxu, exp_vec(16'hFFFE, 3'd4)); end
        release_set();
    endtask

    task automatic test_handshake();
        logic [15:0] b = 16'($urandom);
        logic [DW*ROWS-1:0] snap;
        do_fetch(b, 3'd4, 2);
        n_cmp++;
        if (obs_en !== 4 || obs_vedge !== 7) begin n_bad++; $display("FAIL hs_issue_start: got %0d reads edge %0d want 4 reads edge 7", obs_en, obs_vedge); end
        snap = exp_vec(b, 3'd4);
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            @(negedge clk);
            n_cmp++;
            if ({weights_valid, busy, done, mem_en} !== 4'b1100 || weight_to_mxu !== snap) begin
                n_bad++; $display("FAIL hs_hold%0d: got v%b b%b d%b e%b %h want 1100 %h", i, weights_valid, busy, done, mem_en, weight_to_mxu, snap);
            end
        end
        start = 1'b1; weight_ack = 1'b1;
        @(negedge clk);
        start = 1'b0; weight_ack = 1'b0;
        n_cmp++;
        if (weights_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL hs_ack_start: got valid %b busy %b want 0 0", weights_valid, busy); end
        weight_ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || mem_en !== 1'b0 || weight_to_mxu !== snap) begin n_bad++; $display("FAIL hs_idle_ack: got busy %b en %b want 0 0 and rows kept", busy, mem_en); end
        start = 1'b1; base_addr = 16'h0700; num_rows = 3'd3;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 16'h0700) begin n_bad++; $display("FAIL hs_start_wins: got busy %b en %b addr %h want 1 1 0700", busy, mem_en, mem_addr); end
        for (int c = 0; c < 50 && !weights_valid; c++) @(negedge clk);
        weight_ack = 1'b0;
        n_cmp++;
        if (weights_valid !== 1'b1 || weight_to_mxu !== exp_vec(16'h0700, 3'd3)) begin n_bad++; $display("FAIL hs_ack_early: got valid %b %h want 1 %h", weights_valid, weight_to_mxu, exp_vec(16'h0700, 3'd3)); end
        @(negedge clk);
        n_cmp++;
        if (weights_valid !== 1'b1) begin n_bad++; $display("FAIL hs_hold_after_early_ack: got %b want 1", weights_valid); end
        release_set();
    endtask

    task automatic test_reset_mid();
        logic [15:0] b = 16'($urandom);
        logic [DW*ROWS-1:0] ev = exp_vec(b, 3'd4);
        base_addr = b; num_rows = 3'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || weights_valid !== 1'b0 || weight_to_mxu !== {64'h0, ev[191:0]}) begin
            n_bad++; $display("FAIL rm_pending: got busy %b valid %b %h want 1 0 %h", busy, weights_valid, weight_to_mxu, {64'h0, ev[191:0]});
        end
        #1 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({mem_en, mem_addr, weights_valid, busy, done} !== '0 || weight_to_mxu !== '0) begin
            n_bad++; $display("FAIL rm_async: got %b/%h/%b/%b/%b %h want all 0", mem_en, mem_addr, weights_valid, busy, done, weight_to_mxu);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (weight_to_mxu !== '0 || busy !== 1'b0) begin n_bad++; $display("FAIL rm_late_data: got %h busy %b want 0 0", weight_to_mxu, busy); end
        do_fetch(16'h0900, 3'd4, 0);
        n_cmp++;
        if (obs_vedge !== 7 || weight_to_mxu !== exp_vec(16'h0900, 3'd4)) begin n_bad++; $display("FAIL rm_fresh: got edge %0d %h want 7 %h", obs_vedge, weight_to_mxu, exp_vec(16'h0900, 3'd4)); end
        release_set();
    endtask

`ifdef WFETCH_MEM_GNT_EN
    task automatic test_mem_gnt();
        logic [15:0] b = 16'h0400;
        int g, k = 0;
        gnt_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        g = exp_g(4);
        do_fetch(b, 3'd4, 0);
        n_cmp++;
        if (obs_en !== g || obs_first !== 1) begin n_bad++; $display("FAIL gnt_en: got %0d from %0d want %0d from 1", obs_en, obs_first, g); end
        for (int i = 0; i < obs_addr.size(); i++) begin
            n_cmp++;
            if (obs_addr[i] !== 16'(b + k)) begin n_bad++; $display("FAIL gnt_addr%0d: got %h want %h", i, obs_addr[i], 16'(b + k)); end
            if (obs_gnt[i]) k++;
        end
        n_cmp++;
        if (obs_vedge !== g + LAT + 1 || weight_to_mxu !== exp_vec(b, 3'd4)) begin
            n_bad++; $display("FAIL gnt_valid: got edge %0d %h want %0d %h", obs_vedge, weight_to_mxu, g + LAT + 1, exp_vec(b, 3'd4));
        end
        gnt_pat.delete();
        release_set();
    endtask
`endif

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            logic [15:0] b = 16'($urandom);
            logic [2:0] nr = 3'($urandom);
            int n = n_eff(nr), g, k = 0;
            salt = $urandom;
            mem_ovr.delete();
            gnt_pat.delete();
`ifdef WFETCH_MEM_GNT_EN
            for (int i = 0; i < 8; i++) gnt_pat.push_back(1'($urandom));
`endif
            g = exp_g(n);
            do_fetch(b, nr, $urandom_range(0, g + LAT));
            n_cmp++;
            if (obs_en !== g || obs_first !== 1 || obs_last !== g) begin
                n_bad++; $display("FAIL rnd%0d_en: got %0d cycles %0d..%0d want %0d cycles 1..%0d", it, obs_en, obs_first, obs_last, g, g);
            end
            for (int i = 0; i < obs_addr.size(); i++) begin
                n_cmp++;
                if (obs_addr[i] !== 16'(b + k)) begin n_bad++; $display("FAIL rnd%0d_addr%0d: got %h want %h", it, i, obs_addr[i], 16'(b + k)); end
                if (obs_gnt[i]) k++;
            end
            n_cmp++;
            if (obs_vedge !== g + LAT + 1 || obs_done !== 1'b1) begin
                n_bad++; $display("FAIL rnd%0d_valid: got edge %0d done %b want %0d 1", it, obs_vedge, obs_done, g + LAT + 1);
            end
            n_cmp++;
            if (weight_to_mxu !== exp_vec(b, nr)) begin n_bad++; $display("FAIL rnd%0d_weights: got %h want %h", it, weight_to_mxu, exp_vec(b, nr)); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            n_cmp++;
            if (weights_valid !== 1'b1 || weight_to_mxu !== exp_vec(b, nr)) begin n_bad++; $display("FAIL rnd%0d_hold: got valid %b %h", it, weights_valid, weight_to_mxu); end
            release_set();
        end
        gnt_pat.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_wrap();
        test_handshake();
        test_reset_mid();
`ifdef WFETCH_MEM_GNT_EN
        test_mem_gnt();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
